lvds_event_stamper: RTL and testbench



---
 rtl/lvds_event_stamper.sv | 149 ++++++++++++++
 tb/tb_lvds_event_stamper.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lvds_event_stamper.sv
// Event front-end: synchronises the LVDS event lines and trigger, stamps each qualified
// rising edge into a per-channel pending slot, and drains the slots to the FIFO round-robin.
module lvds_event_stamper #(
  parameter int N_CH = 16,
  parameter int TS_W = 28
) (
  input  logic              clk200,
  input  logic              rst,
  input  logic [N_CH-1:0]   oLVDS,
  input  logic              trigger,
  input  logic              fifo_full,
  output logic              fifo_wr_en,
  output logic [TS_W+3:0]   fifo_din,
  output logic [TS_W-1:0]   ts_now,
  output logic [N_CH-1:0]   pending,
  output logic [15:0]       drop_count
);

  localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam int CNT_W = $clog2(N_CH + 1);

  logic [N_CH-1:0] r_lvds_s1;
  logic [N_CH-1:0] r_lvds_s2;
  logic [N_CH-1:0] r_lvds_d;
  logic            r_trig_s1;
  logic            r_trig_s2;
  logic [TS_W-1:0] r_ts;
  logic [N_CH-1:0] r_pending;
  logic [TS_W-1:0] r_ts_cap [N_CH];
  logic [CH_W-1:0] r_rr;
  logic [15:0]     r_drop;

  logic [N_CH-1:0] w_edge;
  logic [N_CH-1:0] w_cap;
  logic [N_CH-1:0] w_drain;
  logic [N_CH-1:0] w_drop;
  logic [CH_W-1:0] w_sel;
  logic [CH_W-1:0] w_scan_idx;
  logic            w_found;
  logic            w_wr_en;
  logic [CNT_W-1:0] w_drop_n;
  logic [16:0]     w_drop_sum;

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_lvds_s1 <= '0;
      r_lvds_s2 <= '0;
      r_lvds_d  <= '0;
      r_trig_s1 <= 1'b0;
      r_trig_s2 <= 1'b0;
    end else begin
      r_lvds_s1 <= oLVDS;
      r_lvds_s2 <= r_lvds_s1;
      r_lvds_d  <= r_lvds_s2;
      r_trig_s1 <= trigger;
      r_trig_s2 <= r_trig_s1;
    end
  end

  assign w_edge = r_lvds_s2 & ~r_lvds_d;
  assign w_cap  = w_edge & {N_CH{r_trig_s2}};

  // Counter sits at zero while idle so the first triggered cycle reads ts=0.
  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_ts <= '0;
    end else if (r_trig_s2) begin
      r_ts <= r_ts + TS_W'(1);
    end else begin
      r_ts <= '0;
    end
  end

  always_comb begin
    w_sel      = '0;
    w_found    = 1'b0;
    w_scan_idx = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_scan_idx = r_rr + CH_W'(k);
      if (!w_found && r_pending[w_scan_idx]) begin
        w_sel   = w_scan_idx;
        w_found = 1'b1;
      end
    end
  end

  assign w_wr_en = (|r_pending) & ~fifo_full;

  // A capture on the channel being drained refills the slot instead of dropping.
  genvar gi;
  generate
    for (gi = 0; gi < N_CH; gi++) begin : g_ch
      assign w_drain[gi] = w_wr_en & (w_sel == CH_W'(gi));
      assign w_drop[gi]  = w_cap[gi] & r_pending[gi] & ~w_drain[gi];
    end
  endgenerate

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_pending <= '0;
      for (int k = 0; k < N_CH; k++) begin
        r_ts_cap[k] <= '0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (w_cap[k] && !w_drop[k]) begin
          r_pending[k] <= 1'b1;
          r_ts_cap[k]  <= r_ts;
        end else if (w_drain[k]) begin
          r_pending[k] <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_rr <= '0;
    end else if (w_wr_en) begin
      r_rr <= w_sel + CH_W'(1);
    end
  end

  always_comb begin
    w_drop_n = '0;
    for (int k = 0; k < N_CH; k++) begin
      w_drop_n = w_drop_n + CNT_W'(w_drop[k]);
    end
  end

  assign w_drop_sum = {1'b0, r_drop} + 17'(w_drop_n);

  always_ff @(posedge clk200 or posedge rst) begin
    if (rst) begin
      r_drop <= '0;
    end else if (w_drop_sum[16]) begin
      r_drop <= 16'hFFFF;
    end else begin
      r_drop <= w_drop_sum[15:0];
    end
  end

  assign fifo_wr_en = w_wr_en;
  assign fifo_din   = {4'(w_sel), r_ts_cap[w_sel]};
  assign ts_now     = r_ts;
  assign pending    = r_pending;
  assign drop_count = r_drop;

endmodule

// File: tb/tb_lvds_event_stamper.sv
// Scoreboard bench: stimulus pushes expected FIFO words, forked monitors pop and compare.
module tb_lvds_event_stamper;

  typedef struct {
    logic [31:0] din;
    int          cyc;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] lvds;
  logic        trig;
  logic        full;
  logic        wr_en;
  logic [31:0] din;
  logic [27:0] ts_now;
  logic [15:0] pend;
  logic [15:0] drop;

  logic [15:0] w_lvds;
  logic        w_trig;
  logic        w_full;
  logic        w_wr_en;
  logic [7:0]  w_din;
  logic [3:0]  w_ts;
  logic [15:0] w_pend;
  logic [15:0] w_drop;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  bit   done   = 0;
  exp_t q_main[$];
  logic [7:0] q_w[$];

  lvds_event_stamper #(.N_CH(16), .TS_W(28)) u_dut (
    .clk200(clk), .rst(rst), .oLVDS(lvds), .trigger(trig), .fifo_full(full),
    .fifo_wr_en(wr_en), .fifo_din(din), .ts_now(ts_now), .pending(pend), .drop_count(drop)
  );

  lvds_event_stamper #(.N_CH(16), .TS_W(4)) u_dut_wrap (
    .clk200(clk), .rst(rst), .oLVDS(w_lvds), .trigger(w_trig), .fifo_full(w_full),
    .fifo_wr_en(w_wr_en), .fifo_din(w_din), .ts_now(w_ts), .pending(w_pend), .drop_count(w_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse(input logic [15:0] mask);
    lvds = mask;
    tick();
    tick();
    lvds = '0;
    tick();
    tick();
  endtask

  task automatic push(input logic [3:0] ch, input logic [27:0] ts, input int at_cyc);
    exp_t e;
    e.din = {ch, ts};
    e.cyc = at_cyc;
    q_main.push_back(e);
  endtask

  initial begin
    int          tm;
    int          tw;
    int          rel;
    logic [27:0] e;
    rst = 1'b1; lvds = '0; trig = 1'b0; full = 1'b0;
    w_lvds = '0; w_trig = 1'b0; w_full = 1'b0;
    fork
      begin : stimulus
        repeat (3) tick();
        @(negedge clk);
        chk("rst_wr_en", 64'(wr_en), 64'(0));
        chk("rst_din", 64'(din), 64'(0));
        chk("rst_ts_now", 64'(ts_now), 64'(0));
        chk("rst_pending", 64'(pend), 64'(0));
        chk("rst_drop", 64'(drop), 64'(0));
        tick();
        rst = 1'b0;

        // gating: trigger low
        tick();
        pulse(16'h0020);
        repeat (4) tick();
        @(negedge clk);
        chk("gate_pending", 64'(pend), 64'(0));
        chk("gate_drop", 64'(drop), 64'(0));
        chk("gate_ts_now", 64'(ts_now), 64'(0));

        // single event
        tick();
        trig = 1'b1;
        tm = cyc + 1;
        repeat (100) tick();
        @(negedge clk);
        chk("ts_now_count", 64'(ts_now), 64'(cyc - tm - 1));
        tick();
        e = 28'(cyc + 1 - tm);
        push(4'd0, e, cyc + 3);
        pulse(16'h0001);
        repeat (4) tick();
        @(negedge clk);
        chk("single_drop", 64'(drop), 64'(0));

        // simultaneous channels 1, 3, 15
        tick();
        e = 28'(cyc + 1 - tm);
        push(4'd1, e, cyc + 3);
        push(4'd3, e, cyc + 4);
        push(4'd15, e, cyc + 5);
        pulse(16'h800A);
        repeat (4) tick();
        @(negedge clk);
        chk("simul_pending", 64'(pend), 64'(0));

        // backpressure and drop on channel 2
        tick();
        full = 1'b1;
        tick();
        e = 28'(cyc + 1 - tm);
        pulse(16'h0004);
        repeat (16) tick();
        pulse(16'h0004);
        repeat (4) tick();
        @(negedge clk);
        chk("bp_pending", 64'(pend), 64'h0004);
        chk("bp_drop", 64'(drop), 64'(1));
        chk("bp_wr_en", 64'(wr_en), 64'(0));
        tick();
        push(4'd2, e, cyc);
        full = 1'b0;
        repeat (4) tick();

        // round-robin from rr=3: channel 4 before channel 1
        full = 1'b1;
        tick();
        e = 28'(cyc + 1 - tm);
        pulse(16'h0012);
        repeat (2) tick();
        push(4'd4, e, cyc);
        push(4'd1, e, cyc + 1);
        full = 1'b0;
        repeat (4) tick();

        // pending slot drains after trigger falls
        full = 1'b1;
        tick();
        e = 28'(cyc + 1 - tm);
        pulse(16'h0080);
        trig = 1'b0;
        repeat (5) tick();
        @(negedge clk);
        chk("trigfall_ts_now", 64'(ts_now), 64'(0));
        chk("trigfall_pending", 64'(pend), 64'h0080);
        tick();
        push(4'd7, e, cyc);
        full = 1'b0;
        repeat (4) tick();

        // wrap with a 4-bit timestamp
        tick();
        w_trig = 1'b1;
        tw = cyc + 1;
        for (int k = 0; k < 40; k++) begin
          tick();
          rel = cyc + 1 - tw;
          if (rel == 15) begin w_lvds[0] = 1'b1; q_w.push_back(8'h0F); end
          if (rel == 16) begin w_lvds[1] = 1'b1; q_w.push_back(8'h10); end
          if (rel == 17) w_lvds[0] = 1'b0;
          if (rel == 18) w_lvds[1] = 1'b0;
          @(negedge clk);
          chk("wrap_ts_now", 64'(w_ts), 64'((cyc >= tw + 1) ? ((cyc - tw - 1) % 16) : 0));
        end
        w_trig = 1'b0;

        // reset with four slots pending behind a full FIFO
        trig = 1'b1;
        full = 1'b1;
        repeat (5) tick();
        pulse(16'h1241);
        repeat (2) tick();
        @(negedge clk);
        chk("prerst_pending", 64'(pend), 64'h1241);
        chk("prerst_drop", 64'(drop), 64'(1));
        @(posedge clk);
        #1 rst = 1'b1;
        #1;
        chk("midrst_pending", 64'(pend), 64'(0));
        chk("midrst_wr_en", 64'(wr_en), 64'(0));
        chk("midrst_drop", 64'(drop), 64'(0));
        chk("midrst_ts_now", 64'(ts_now), 64'(0));
        rst = 1'b0;
        full = 1'b0;
        repeat (10) tick();
        done = 1'b1;
      end
      begin : monitor_main
        while (!done) begin
          @(negedge clk);
          if (wr_en) begin
            chk("write_expected", 64'(q_main.size() > 0), 64'(1));
            chk("write_while_full", 64'(full), 64'(0));
            $display("write ch=%0d ts=%0d cycle=%0d", din[31:28], din[27:0], cyc);
            if (q_main.size() > 0) begin
              exp_t ex;
              ex = q_main.pop_front();
              chk("fifo_din", 64'(din), 64'(ex.din));
              if (ex.cyc >= 0) chk("write_cycle", 64'(cyc), 64'(ex.cyc));
            end
          end
        end
      end
      begin : monitor_wrap
        while (!done) begin
          @(negedge clk);
          if (w_wr_en) begin
            chk("wrap_write_expected", 64'(q_w.size() > 0), 64'(1));
            $display("wrap write ch=%0d ts=%0d cycle=%0d", w_din[7:4], w_din[3:0], cyc);
            if (q_w.size() > 0) begin
              logic [7:0] wx;
              wx = q_w.pop_front();
              chk("wrap_fifo_din", 64'(w_din), 64'(wx));
            end
          end
        end
      end
    join
    chk("main_writes_missing", 64'(q_main.size()), 64'(0));
    chk("wrap_writes_missing", 64'(q_w.size()), 64'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
